// File: rtl/uart_frame_arbiter_if.sv
// Handshake bundle between N frame sources, the arbiter and the uart_tx byte port.
//  req_valid/req_data/req_last/req_ready : per-requester byte stream (byte i at [8*i +: 8])
//  tx_data/tx_valid/tx_ready             : byte stream towards uart_tx
//  grant/busy/frame_done/timeout_err     : arbiter status
// master = arbiter side, slave = requesters + uart_tx side.
interface uart_frame_arbiter_if #(
    parameter int unsigned N_REQ = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic [N_REQ-1:0]   grant;
    logic               busy;
    logic               frame_done;
    logic               timeout_err;

    modport master (
        input  req_valid, req_data, req_last, tx_ready,
        output req_ready, tx_data, tx_valid, grant, busy, frame_done, timeout_err
    );

    modport slave (
        output req_valid, req_data, req_last, tx_ready,
        input  req_ready, tx_data, tx_valid, grant, busy, frame_done, timeout_err
    );
endinterface

// File: rtl/uart_frame_arbiter.sv
// Round-robin, frame-atomic arbiter sharing one 8N1 uart_tx between N_REQ frame sources.
// Enforces an idle gap after every frame and aborts a frame whose source stalls too long.
// Ports:
//  clk, rst : clock, asynchronous active-high reset
//  bus      : uart_frame_arbiter_if.master (requester streams, uart_tx stream, status)
// tx_valid/tx_data/req_ready are a combinational pass-through of the granted source while
// streaming; grant, frame_done and timeout_err are registered; busy decodes the state register.
module uart_frame_arbiter #(
    parameter int unsigned N_REQ          = 2,
    parameter int unsigned GAP_CYCLES     = 4340,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_frame_arbiter_if.master bus
);
    localparam int unsigned IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    // Where a frame ends (normally or aborted): straight back to IDLE when no gap is wanted.
    localparam state_t END_STATE = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

    state_t             state;
    logic [IDX_W-1:0]   g_idx;
    logic [IDX_W-1:0]   rr_ptr;
    logic [N_REQ-1:0]   grant_q;
    logic [STALL_W-1:0] stall_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               frame_done_q;
    logic               timeout_err_q;

    logic               sel_any;
    logic [IDX_W-1:0]   sel_idx;
    logic               g_valid;
    logic               g_last;
    logic               xfer;
    logic [IDX_W-1:0]   rr_next;
    logic [N_REQ-1:0]   req_ready_c;

    // Round-robin pick: first valid requester starting at rr_ptr.
    always_comb begin
        int unsigned cand;
        sel_any = 1'b0;
        sel_idx = '0;
        cand    = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = 32'(rr_ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!sel_any && bus.req_valid[IDX_W'(cand)]) begin
                sel_any = 1'b1;
                sel_idx = IDX_W'(cand);
            end
        end
    end

    // Pass-through of the granted source while streaming.
    assign g_valid = (state == ST_STREAM) && bus.req_valid[g_idx];
    assign g_last  = bus.req_last[g_idx];
    assign xfer    = g_valid && bus.tx_ready;
    assign rr_next = (g_idx == IDX_W'(N_REQ - 1)) ? '0 : g_idx + IDX_W'(1);

    always_comb begin
        req_ready_c = '0;
        if (xfer) begin
            req_ready_c[g_idx] = 1'b1;
        end
    end

    assign bus.tx_valid    = g_valid;
    assign bus.tx_data     = g_valid ? bus.req_data[{g_idx, 3'b000} +: 8] : 8'h00;
    assign bus.req_ready   = req_ready_c;
    assign bus.grant       = grant_q;
    assign bus.busy        = (state != ST_IDLE);
    assign bus.frame_done  = frame_done_q;
    assign bus.timeout_err = timeout_err_q;

    // Arbitration FSM with stall and gap counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            g_idx         <= '0;
            rr_ptr        <= '0;
            grant_q       <= '0;
            stall_cnt     <= '0;
            gap_cnt       <= '0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sel_any) begin
                        g_idx     <= sel_idx;
                        grant_q   <= N_REQ'(1) << sel_idx;
                        stall_cnt <= '0;
                        state     <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (xfer) begin
                        stall_cnt <= '0;
                        if (g_last) begin
                            frame_done_q <= 1'b1;
                            rr_ptr       <= rr_next;
                            grant_q      <= '0;
                            gap_cnt      <= '0;
                            state        <= END_STATE;
                        end
                    end else if (!bus.req_valid[g_idx]) begin
                        // This stall cycle brings the count to TIMEOUT_CYCLES: abort.
                        if (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1)) begin
                            timeout_err_q <= 1'b1;
                            rr_ptr        <= rr_next;
                            grant_q       <= '0;
                            gap_cnt       <= '0;
                            stall_cnt     <= '0;
                            state         <= END_STATE;
                        end else begin
                            stall_cnt <= stall_cnt + STALL_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        gap_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Bench for uart_frame_arbiter: random frame sources and a uart_tx model (ready drops for one
// cycle after each accept) drive the DUT; a byte monitor is compared against a frame-level
// round-robin model that simply concatenates whole frames in arbitration order.
module tb_uart_frame_arbiter;
    localparam int unsigned N_REQ          = 2;
    localparam int unsigned GAP_CYCLES     = 4;
    localparam int unsigned TIMEOUT_CYCLES = 8;

    logic clk;
    logic rst;

    uart_frame_arbiter_if #(.N_REQ(N_REQ)) bus ();

    uart_frame_arbiter #(
        .N_REQ(N_REQ),
        .GAP_CYCLES(GAP_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    int cyc;
    int model_rr;
    int fd_cnt;
    int to_cnt;

    // Source queues entries are {last, data}; log/expect entries are {source, data}.
    logic [8:0] src0_q[$];
    logic [8:0] src1_q[$];
    logic [8:0] m0_q[$];
    logic [8:0] m1_q[$];
    logic [8:0] exp_q[$];
    logic [8:0] mon_q[$];
    int         mon_cyc[$];

    logic [1:0] pause;
    bit         uart_hold;
    bit         acc_seen;
    logic [1:0] rdy_seen;

    always @(posedge clk) cyc = cyc + 1;

    // Requesters and uart_tx model: update just after the active edge.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (rdy_seen[0] && src0_q.size() > 0) void'(src0_q.pop_front());
            if (rdy_seen[1] && src1_q.size() > 0) void'(src1_q.pop_front());
        end
        bus.req_valid[0]   = (src0_q.size() > 0) && !pause[0];
        bus.req_data[7:0]  = (src0_q.size() > 0) ? src0_q[0][7:0] : 8'h00;
        bus.req_last[0]    = (src0_q.size() > 0) ? src0_q[0][8] : 1'b0;
        bus.req_valid[1]   = (src1_q.size() > 0) && !pause[1];
        bus.req_data[15:8] = (src1_q.size() > 0) ? src1_q[0][7:0] : 8'h00;
        bus.req_last[1]    = (src1_q.size() > 0) ? src1_q[0][8] : 1'b0;
        bus.tx_ready       = !uart_hold && !acc_seen;
    end

    // Monitor on the falling edge: what will transfer on the next rising edge.
    always @(negedge clk) begin
        rdy_seen = bus.req_ready;
        acc_seen = bus.tx_valid && bus.tx_ready;
        if (!rst) begin
            if (acc_seen) begin
                mon_q.push_back({bus.grant[1], bus.tx_data});
                mon_cyc.push_back(cyc);
            end
            if (bus.frame_done) fd_cnt++;
            if (bus.timeout_err) to_cnt++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_byte(input int src, input logic [7:0] d, input bit last);
        if (src == 0) begin
            src0_q.push_back({last, d});
            m0_q.push_back({last, d});
        end else begin
            src1_q.push_back({last, d});
            m1_q.push_back({last, d});
        end
    endtask

    task automatic push_frame(input int src, input int len);
        for (int i = 0; i < len; i++) push_byte(src, 8'($urandom_range(0, 255)), i == len - 1);
    endtask

    function automatic int model_size(input int idx);
        return (idx == 0) ? m0_q.size() : m1_q.size();
    endfunction

    // Whole frames leave in round-robin order; pointer moves past each winner.
    task automatic model_arbitrate();
        logic [8:0] b;
        int pick;
        while (m0_q.size() + m1_q.size() > 0) begin
            pick = -1;
            for (int k = 0; k < N_REQ; k++) begin
                if (pick < 0 && model_size((model_rr + k) % N_REQ) > 0) pick = (model_rr + k) % N_REQ;
            end
            do begin
                b = (pick == 0) ? m0_q.pop_front() : m1_q.pop_front();
                exp_q.push_back({pick[0], b[7:0]});
            end while (!b[8]);
            model_rr = (pick + 1) % N_REQ;
        end
    endtask

    task automatic clear_logs();
        mon_q.delete();
        mon_cyc.delete();
        exp_q.delete();
        fd_cnt = 0;
        to_cnt = 0;
    endtask

    task automatic wait_quiet(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (src0_q.size() == 0 && src1_q.size() == 0 && !bus.busy) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00 || bus.req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_tx got valid=%b data=%h ready=%b exp 0/00/00", bus.tx_valid, bus.tx_data, bus.req_ready);
        end
        checks++;
        if (bus.grant !== 2'b00 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_grant got grant=%b busy=%b exp 00/0", bus.grant, bus.busy);
        end
        checks++;
        if (bus.frame_done !== 1'b0 || bus.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses got fd=%b to=%b exp 0/0", bus.frame_done, bus.timeout_err);
        end
        rst = 1'b0;
        model_rr = 0;
        step();
    endtask

    task automatic test_single_frame();
        int bad_grant, fd_k, gap_k;
        clear_logs();
        push_byte(0, 8'h7B, 1'b0);
        push_byte(0, 8'h22, 1'b0);
        push_byte(0, 8'h0A, 1'b1);
        model_arbitrate();
        bad_grant = 0;
        fd_k = -1;
        gap_k = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.tx_valid && bus.grant !== 2'b01) bad_grant++;
            if (bus.frame_done) fd_k = i;
            if (fd_k >= 0 && gap_k < 0 && !bus.busy) gap_k = i - fd_k;
        end
        checks++;
        if (bad_grant != 0) begin errors++; $display("FAIL single_grant got %0d bad cycles exp 0", bad_grant); end
        checks++;
        if (fd_cnt != 1) begin errors++; $display("FAIL single_done got %0d pulses exp 1", fd_cnt); end
        checks++;
        if (gap_k != 4) begin errors++; $display("FAIL single_gap got busy low after %0d cycles exp 4", gap_k); end
        checks++;
        if (mon_q.size() != exp_q.size()) begin errors++; $display("FAIL single_len got %0d exp %0d", mon_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            checks++;
            if (mon_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_byte%0d got %h exp %h", i, mon_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_contention();
        bit ok;
        int first1;
        clear_logs();
        rst = 1'b1;
        repeat (2) step();
        model_rr = 0;
        push_frame(1, 3);
        push_frame(0, 4);
        rst = 1'b0;
        model_arbitrate();
        wait_quiet(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL contention_done got stuck exp idle"); end
        checks++;
        if (mon_q.size() != exp_q.size()) begin errors++; $display("FAIL contention_len got %0d exp %0d", mon_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            checks++;
            if (mon_q[i] !== exp_q[i]) begin errors++; $display("FAIL contention_byte%0d got %h exp %h", i, mon_q[i], exp_q[i]); end
        end
        first1 = -1;
        for (int i = 0; i < mon_q.size(); i++) if (first1 < 0 && mon_q[i][8]) first1 = i;
        checks++;
        if (first1 < 1) begin
            errors++;
            $display("FAIL contention_order got first req1 byte at %0d exp 4", first1);
        end else if (mon_cyc[first1] - mon_cyc[first1 - 1] != GAP_CYCLES + 2) begin
            errors++;
            $display("FAIL contention_gap got %0d cycles exp %0d", mon_cyc[first1] - mon_cyc[first1 - 1], GAP_CYCLES + 2);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_logs();
        for (int f = 0; f < 4; f++) begin
            push_frame(0, 2);
            push_frame(1, 2);
        end
        model_arbitrate();
        wait_quiet(400, ok);
        checks++;
        if (!ok || mon_q.size() != 16) begin errors++; $display("FAIL b2b_count got %0d bytes exp 16", mon_q.size()); end
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            checks++;
            if (mon_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d got %h exp %h", i, mon_q[i], exp_q[i]); end
        end
        checks++;
        if (fd_cnt != 8) begin errors++; $display("FAIL b2b_done got %0d exp 8", fd_cnt); end
    endtask

    task automatic test_timeout();
        logic [7:0] b [4];
        logic [1:0] grant_at;
        bit ok;
        int k_to;
        clear_logs();
        for (int i = 0; i < 4; i++) begin
            b[i] = 8'($urandom_range(0, 255));
            src1_q.push_back({i == 3, b[i]});
        end
        // First byte goes out; the remainder becomes a fresh frame once re-granted.
        exp_q.push_back({1'b1, b[0]});
        for (int i = 1; i < 4; i++) m1_q.push_back({i == 3, b[i]});
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            if (mon_q.size() == 1) ok = 1'b1;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL timeout_first got %0d bytes exp 1", mon_q.size()); end
        pause[1] = 1'b1;
        k_to = -1;
        grant_at = 2'bxx;
        for (int k = 1; k <= 20 && k_to < 0; k++) begin
            step();
            if (bus.timeout_err) begin
                k_to = k;
                grant_at = bus.grant;
            end
        end
        checks++;
        if (k_to < 8 || k_to > 9) begin errors++; $display("FAIL timeout_when got stall cycle %0d exp 8..9", k_to); end
        checks++;
        if (grant_at !== 2'b00) begin errors++; $display("FAIL timeout_grant got %b exp 00", grant_at); end
        checks++;
        if (mon_q.size() != 1) begin errors++; $display("FAIL timeout_fwd got %0d bytes exp 1", mon_q.size()); end
        model_rr = (1 + 1) % N_REQ;
        pause[1] = 1'b0;
        push_frame(0, 2);
        model_arbitrate();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.tx_valid !== 1'b0 || bus.req_ready !== 2'b00) begin
                errors++;
                $display("FAIL timeout_gap%0d got valid=%b ready=%b exp 0/00", i, bus.tx_valid, bus.req_ready);
            end
        end
        wait_quiet(200, ok);
        checks++;
        if (mon_q.size() != exp_q.size()) begin errors++; $display("FAIL timeout_len got %0d exp %0d", mon_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            checks++;
            if (mon_q[i] !== exp_q[i]) begin errors++; $display("FAIL timeout_byte%0d got %h exp %h", i, mon_q[i], exp_q[i]); end
        end
        checks++;
        if (to_cnt != 1) begin errors++; $display("FAIL timeout_count got %0d exp 1", to_cnt); end
    endtask

    task automatic test_ready_stall();
        bit ok;
        clear_logs();
        push_frame(0, 5);
        model_arbitrate();
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            if (mon_q.size() == 2) ok = 1'b1;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_start got %0d bytes exp 2", mon_q.size()); end
        uart_hold = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp_q[2][7:0] || bus.req_ready !== 2'b00 || bus.timeout_err !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d got v=%b d=%h r=%b to=%b exp 1/%h/00/0",
                         i, bus.tx_valid, bus.tx_data, bus.req_ready, bus.timeout_err, exp_q[2][7:0]);
            end
        end
        uart_hold = 1'b0;
        wait_quiet(200, ok);
        checks++;
        if (mon_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_len got %0d exp %0d", mon_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            checks++;
            if (mon_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_byte%0d got %h exp %h", i, mon_q[i], exp_q[i]); end
        end
        checks++;
        if (to_cnt != 0) begin errors++; $display("FAIL stall_timeout got %0d exp 0", to_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b0;
        bit ok;
        clear_logs();
        b0 = 8'($urandom_range(0, 255));
        src0_q.push_back({1'b0, b0});
        for (int i = 1; i < 5; i++) src0_q.push_back({i == 4, 8'($urandom_range(0, 255))});
        exp_q.push_back({1'b0, b0});
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            if (mon_q.size() == 1 && bus.tx_valid && !bus.tx_ready) ok = 1'b1;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL rstmid_start got %0d bytes exp 1 with byte 2 offered", mon_q.size()); end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.tx_valid !== 1'b0 || bus.grant !== 2'b00 || bus.busy !== 1'b0 || bus.req_ready !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_async got v=%b g=%b busy=%b r=%b exp 0/00/0/00", bus.tx_valid, bus.grant, bus.busy, bus.req_ready);
        end
        src0_q.delete();
        step();
        step();
        model_rr = 0;
        push_frame(1, 3);
        push_frame(0, 3);
        rst = 1'b0;
        model_arbitrate();
        wait_quiet(200, ok);
        checks++;
        if (mon_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_len got %0d exp %0d", mon_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            checks++;
            if (mon_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_byte%0d got %h exp %h", i, mon_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        model_rr  = 0;
        fd_cnt    = 0;
        to_cnt    = 0;
        pause     = 2'b00;
        uart_hold = 1'b0;
        acc_seen  = 1'b0;
        rdy_seen  = 2'b00;
        rst       = 1'b1;
        test_reset();
        test_single_frame();
        test_contention();
        test_back_to_back();
        test_timeout();
        test_ready_stall();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
